// File: rtl/sisc_pkg.sv
// Shared types and constants for the SISC execution/control core.
// No logic; backpressure not applicable.
package sisc_pkg;

    typedef enum logic [2:0] {
        START0,
        START1,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ALU_RR = 4'd1;
    localparam logic [3:0] OP_ALU_RI = 4'd2;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_BNE    = 4'd6;
    localparam logic [3:0] OP_BNR    = 4'd7;
    localparam logic [3:0] OP_LOD    = 4'd8;
    localparam logic [3:0] OP_STR    = 4'd9;
    localparam logic [3:0] OP_HLT    = 4'd15;

    localparam logic [1:0] ALU_RR   = 2'b00;
    localparam logic [1:0] ALU_RI   = 2'b01;
    localparam logic [1:0] ALU_ADDR = 2'b10;
    localparam logic [1:0] ALU_IMM  = 2'b11;

    localparam logic [3:0] FN_ADD   = 4'd0;
    localparam logic [3:0] FN_SUB   = 4'd1;
    localparam logic [3:0] FN_AND   = 4'd2;
    localparam logic [3:0] FN_OR    = 4'd3;
    localparam logic [3:0] FN_XOR   = 4'd4;
    localparam logic [3:0] FN_NOT   = 4'd5;
    localparam logic [3:0] FN_SHL   = 4'd6;
    localparam logic [3:0] FN_SHR   = 4'd7;
    localparam logic [3:0] FN_ASR   = 4'd8;
    localparam logic [3:0] FN_PASSB = 4'd9;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/sisc_alu_core.sv
// Combinational 32-bit ALU with {C,V,N,Z} flag generation.
// Latency: 0 cycles (pure combinational); no backpressure.
module sisc_alu_core
    import sisc_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [3:0]  func,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [15:0] imm,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [31:0] immx;
    logic [31:0] opb;
    logic [32:0] sum;
    logic [31:0] diff;
    logic        c_flag;
    logic        v_flag;

    assign immx = sext16(imm);
    assign opb  = (alu_op == ALU_RR) ? rsb : immx;
    assign sum  = {1'b0, rsa} + {1'b0, opb};
    assign diff = rsa - opb;

    always_comb begin
        result = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (alu_op)
            ALU_RR, ALU_RI: begin
                case (func)
                    FN_ADD: begin
                        result = sum[31:0];
                        c_flag = sum[32];
                        v_flag = (rsa[31] == opb[31]) && (sum[31] != rsa[31]);
                    end
                    FN_SUB: begin
                        result = diff;
                        // C reports borrow, not the inverted carry of a+~b+1
                        c_flag = (rsa < opb);
                        v_flag = (rsa[31] != opb[31]) && (diff[31] != rsa[31]);
                    end
                    FN_AND:   result = rsa & opb;
                    FN_OR:    result = rsa | opb;
                    FN_XOR:   result = rsa ^ opb;
                    FN_NOT:   result = ~rsa;
                    FN_SHL:   result = rsa << opb[4:0];
                    FN_SHR:   result = rsa >> opb[4:0];
                    FN_ASR:   result = $signed(rsa) >>> opb[4:0];
                    FN_PASSB: result = opb;
                    default:  result = '0;
                endcase
            end
            ALU_ADDR: result = rsa + immx;
            default:  result = immx;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_C] = c_flag;
        flags[FLAG_V] = v_flag;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// SISC execution core: multicycle control FSM, ALU and branch-target adder.
// Latency: 5 FSM cycles per instruction (HLT parks in DECODE); no backpressure.
module sisc_exec_ctrl
    import sisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instr,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [3:0]  stat,
    input  logic [15:0] pc_in,
    output logic [31:0] alu_result,
    output logic [3:0]  sr_in,
    output logic        sr_enable,
    output logic [15:0] br_addr,
    output logic        rf_we,
    output logic        ir_load,
    output logic        dm_we,
    output logic        pc_rst,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        br_sel,
    output logic        rb_sel,
    output logic        mm_sel,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic        is_alu;
    logic        is_mem;
    logic        cond_hit;
    logic [1:0]  exec_alu_op;
    logic [31:0] alu_res_raw;
    logic [3:0]  alu_flags;
    logic [7:0]  unused_reg_fields;

    assign opcode            = instr[31:28];
    assign mm                = instr[27:24];
    assign imm               = instr[15:0];
    assign unused_reg_fields = instr[23:16];
    assign is_alu            = (opcode == OP_ALU_RR) || (opcode == OP_ALU_RI);
    assign is_mem            = (opcode == OP_LOD) || (opcode == OP_STR);
    assign cond_hit          = |(mm & stat);

    always_comb begin
        exec_alu_op = ALU_RR;
        if (opcode == OP_ALU_RI) exec_alu_op = ALU_RI;
        else if (is_mem)         exec_alu_op = ALU_ADDR;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= START0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_rst    = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        br_sel    = 1'b0;
        rb_sel    = 1'b0;
        mm_sel    = 1'b0;
        alu_op    = ALU_RR;
        wb_sel    = 2'b00;
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        sr_enable = 1'b0;
        case (state)
            START0: begin
                pc_rst    = 1'b1;
                state_nxt = START1;
            end
            START1: state_nxt = FETCH;
            FETCH: begin
                ir_load   = 1'b1;
                pc_write  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = EXECUTE;
                case (opcode)
                    OP_BRA, OP_BRR: begin
                        br_sel = (opcode == OP_BRR);
                        if (cond_hit) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                        end
                    end
                    OP_BNE, OP_BNR: begin
                        br_sel = (opcode == OP_BNR);
                        if (!cond_hit) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                        end
                    end
                    OP_HLT:  state_nxt = DECODE;
                    default: ;
                endcase
            end
            EXECUTE, MEM, WRITEBACK: begin
                // Datapath selects stay stable for the whole back half of the instruction
                alu_op = exec_alu_op;
                mm_sel = is_mem && mm[0];
                rb_sel = (opcode == OP_STR);
                if (state == EXECUTE) begin
                    sr_enable = is_alu;
                    state_nxt = MEM;
                end else if (state == MEM) begin
                    dm_we     = (opcode == OP_STR);
                    state_nxt = WRITEBACK;
                end else begin
                    if (is_alu) begin
                        rf_we  = 1'b1;
                        wb_sel = 2'b00;
                    end else if (opcode == OP_LOD) begin
                        rf_we  = 1'b1;
                        wb_sel = 2'b01;
                    end
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = START0;
        endcase
    end

    sisc_alu_core u_alu (
        .alu_op (alu_op),
        .func   (mm),
        .rsa    (rsa),
        .rsb    (rsb),
        .imm    (imm),
        .result (alu_res_raw),
        .flags  (alu_flags)
    );

    // Datapath outputs are forced quiet while held in reset
    assign alu_result = (state == START0) ? '0 : alu_res_raw;
    assign sr_in      = (state == START0) ? '0 : alu_flags;
    assign br_addr    = (state == START0) ? '0 : (br_sel ? (pc_in + imm) : imm);

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Self-checking bench for sisc_exec_ctrl: instruction vector table plus reset/HLT sequences.
module tb_sisc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] instr;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  stat;
    logic [15:0] pc_in;
    logic [31:0] alu_result;
    logic [3:0]  sr_in;
    logic        sr_enable;
    logic [15:0] br_addr;
    logic        rf_we, ir_load, dm_we;
    logic        pc_rst, pc_write, pc_sel;
    logic        br_sel, rb_sel, mm_sel;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;

    always #5 clk = ~clk;

    sisc_exec_ctrl dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .instr      (instr),
        .rsa        (rsa),
        .rsb        (rsb),
        .stat       (stat),
        .pc_in      (pc_in),
        .alu_result (alu_result),
        .sr_in      (sr_in),
        .sr_enable  (sr_enable),
        .br_addr    (br_addr),
        .rf_we      (rf_we),
        .ir_load    (ir_load),
        .dm_we      (dm_we),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .rb_sel     (rb_sel),
        .mm_sel     (mm_sel),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rsa;
        logic [31:0] rsb;
        logic [3:0]  stat;
        logic [15:0] pc_in;
        logic        chk_alu;
        logic [31:0] exp_res;
        logic [3:0]  exp_sr;
        logic        chk_br;
        logic        taken;
        logic [15:0] exp_br;
    } vec_t;

    typedef struct {
        int          phase;
        logic [13:0] ctrl;
        logic        chk_alu;
        logic [31:0] res;
        logic [3:0]  sr;
        logic        chk_br;
        logic [15:0] br;
    } exp_t;

    localparam int NVEC = 17;
    localparam logic [13:0] CTRL_RESET = 14'h2000;
    localparam logic [13:0] CTRL_FETCH = 14'h1800;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {pc_rst, ir_load, pc_write, pc_sel, br_sel, rb_sel, mm_sel, alu_op, wb_sel, rf_we, dm_we, sr_enable}
    function automatic logic [13:0] dut_ctrl();
        return {pc_rst, ir_load, pc_write, pc_sel, br_sel, rb_sel, mm_sel,
                alu_op, wb_sel, rf_we, dm_we, sr_enable};
    endfunction

    function automatic logic [13:0] exp_ctrl(input logic [3:0] op, input logic [3:0] mm,
                                             input logic taken, input int phase);
        logic       irl = 1'b0, pw = 1'b0, ps = 1'b0, bs = 1'b0, rbs = 1'b0, ms = 1'b0;
        logic       rfw = 1'b0, dwe = 1'b0, sre = 1'b0;
        logic [1:0] aop = 2'b00, wb = 2'b00;
        case (phase)
            0: begin
                irl = 1'b1;
                pw  = 1'b1;
            end
            1: begin
                if (op == 4'd4 || op == 4'd5 || op == 4'd6 || op == 4'd7) begin
                    bs = (op == 4'd5 || op == 4'd7);
                    if (taken) begin
                        pw = 1'b1;
                        ps = 1'b1;
                    end
                end
            end
            default: begin
                if (op == 4'd2) aop = 2'b01;
                else if (op == 4'd8 || op == 4'd9) aop = 2'b10;
                if (op == 4'd8 || op == 4'd9) ms = mm[0];
                if (op == 4'd9) rbs = 1'b1;
                if (phase == 2 && (op == 4'd1 || op == 4'd2)) sre = 1'b1;
                if (phase == 3 && op == 4'd9) dwe = 1'b1;
                if (phase == 4 && (op == 4'd1 || op == 4'd2)) rfw = 1'b1;
                if (phase == 4 && op == 4'd8) begin
                    rfw = 1'b1;
                    wb  = 2'b01;
                end
            end
        endcase
        return {1'b0, irl, pw, ps, bs, rbs, ms, aop, wb, rfw, dwe, sre};
    endfunction

    function automatic vec_t mkv(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] st, input logic [15:0] pc,
                                 input logic ca, input logic [31:0] r, input logic [3:0] s,
                                 input logic cb, input logic tk, input logic [15:0] ba);
        vec_t v;
        v.instr = i;  v.rsa = a;  v.rsb = b;  v.stat = st;  v.pc_in = pc;
        v.chk_alu = ca;  v.exp_res = r;  v.exp_sr = s;
        v.chk_br = cb;  v.taken = tk;  v.exp_br = ba;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Entered on a falling edge while the FSM is in FETCH; returns on the next FETCH falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        instr = v.instr;
        rsa   = v.rsa;
        rsb   = v.rsb;
        stat  = v.stat;
        pc_in = v.pc_in;
        for (int p = 0; p < 5; p++) begin
            e.phase   = p;
            e.ctrl    = exp_ctrl(v.instr[31:28], v.instr[27:24], v.taken, p);
            e.chk_alu = v.chk_alu && (p == 2);
            e.res     = v.exp_res;
            e.sr      = v.exp_sr;
            e.chk_br  = v.chk_br && (p == 1);
            e.br      = v.exp_br;
            sb.push_back(e);
        end
        for (int p = 0; p < 5; p++) begin
            if (p > 0) @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d p%0d ctrl", idx, e.phase), {18'd0, dut_ctrl()}, {18'd0, e.ctrl});
                if (e.chk_alu) begin
                    check($sformatf("v%0d alu_result", idx), alu_result, e.res);
                    check($sformatf("v%0d sr_in", idx), {28'd0, sr_in}, {28'd0, e.sr});
                end
                if (e.chk_br)
                    check($sformatf("v%0d br_addr", idx), {16'd0, br_addr}, {16'd0, e.br});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        //            instr         rsa           rsb           stat   pc       alu  result        sr       br  tk  br_addr
        vecs[0]  = mkv(32'h1012_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 16'h0000, 1, 32'h8000_0000, 4'b0110, 0, 0, 16'h0);
        vecs[1]  = mkv(32'h2112_0005, 32'h0000_0005, 32'h0000_0000, 4'b0000, 16'h0000, 1, 32'h0000_0000, 4'b0001, 0, 0, 16'h0);
        vecs[2]  = mkv(32'h2112_0001, 32'h0000_0000, 32'h0000_0000, 4'b0000, 16'h0000, 1, 32'hFFFF_FFFF, 4'b1010, 0, 0, 16'h0);
        vecs[3]  = mkv(32'h5100_0010, 32'h0,         32'h0,         4'b0001, 16'h0005, 0, 32'h0,         4'b0000, 1, 1, 16'h0015);
        vecs[4]  = mkv(32'h5100_0010, 32'h0,         32'h0,         4'b0000, 16'h0005, 0, 32'h0,         4'b0000, 1, 0, 16'h0015);
        vecs[5]  = mkv(32'h6000_0040, 32'h0,         32'h0,         4'b1011, 16'h0005, 0, 32'h0,         4'b0000, 1, 1, 16'h0040);
        vecs[6]  = mkv(32'h9100_0004, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0000, 16'h0000, 1, 32'h0000_0104, 4'b0000, 0, 0, 16'h0);
        vecs[7]  = mkv(32'h8000_0004, 32'h0000_0100, 32'h0,         4'b0000, 16'h0000, 1, 32'h0000_0104, 4'b0000, 0, 0, 16'h0);
        vecs[8]  = mkv(32'h1200_0000, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 16'h0000, 1, 32'h0000_F000, 4'b0000, 0, 0, 16'h0);
        vecs[9]  = mkv(32'h2600_001F, 32'h0000_0001, 32'h0,         4'b0000, 16'h0000, 1, 32'h8000_0000, 4'b0010, 0, 0, 16'h0);
        vecs[10] = mkv(32'h1800_0000, 32'h8000_0000, 32'h0000_0004, 4'b0000, 16'h0000, 1, 32'hF800_0000, 4'b0010, 0, 0, 16'h0);
        vecs[11] = mkv(32'h1100_0000, 32'h8000_0000, 32'h0000_0001, 4'b0000, 16'h0000, 1, 32'h7FFF_FFFF, 4'b0100, 0, 0, 16'h0);
        vecs[12] = mkv(32'h1000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 16'h0000, 1, 32'h0000_0000, 4'b1001, 0, 0, 16'h0);
        vecs[13] = mkv(32'h2900_8000, 32'h1234_5678, 32'h0,         4'b0000, 16'h0000, 1, 32'hFFFF_8000, 4'b0010, 0, 0, 16'h0);
        vecs[14] = mkv(32'h7200_FFF0, 32'h0,         32'h0,         4'b0010, 16'h0100, 0, 32'h0,         4'b0000, 1, 0, 16'h00F0);
        vecs[15] = mkv(32'h4400_1234, 32'h0,         32'h0,         4'b0100, 16'h0100, 0, 32'h0,         4'b0000, 1, 1, 16'h1234);
        vecs[16] = mkv(32'h3000_0000, 32'h0,         32'h0,         4'b1111, 16'h0000, 0, 32'h0,         4'b0000, 0, 0, 16'h0);

        rst_f = 1'b0;
        instr = '0;
        rsa   = '0;
        rsb   = '0;
        stat  = '0;
        pc_in = '0;

        @(negedge clk);
        #1;
        check("reset START0 ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_RESET});
        rst_f = 1'b1;
        @(negedge clk);
        #1;
        check("START1 ctrl", {18'd0, dut_ctrl()}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset dropped mid-instruction while in EXECUTE
        instr = 32'h1012_0000;
        rsa   = 32'h7FFF_FFFF;
        rsb   = 32'h0000_0001;
        #1;
        check("pre-reset FETCH ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_FETCH});
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre-reset EXECUTE sr_enable", {31'd0, sr_enable}, 32'd1);
        rst_f = 1'b0;
        #1;
        check("async reset ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_RESET});
        @(negedge clk);
        #1;
        check("held reset ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_RESET});
        rst_f = 1'b1;
        @(negedge clk);
        #1;
        check("post-reset START1 ctrl", {18'd0, dut_ctrl()}, 32'd0);
        @(negedge clk);
        #1;
        check("post-reset FETCH ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_FETCH});

        // HLT must park the FSM: no further fetches until reset
        instr = 32'hF000_0000;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("HLT cycle %0d ctrl", c), {18'd0, dut_ctrl()}, 32'd0);
        end
        rst_f = 1'b0;
        #1;
        check("HLT reset ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_RESET});
        rst_f = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("HLT recovery FETCH ctrl", {18'd0, dut_ctrl()}, {18'd0, CTRL_FETCH});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
